uart_rx_frontend: RTL and testbench
===================================

// Module: uart_rx_frontend
// PURPOSE
//  Serial UART receiver directly upstream of the CPU UART controller: samples the async rxd pin,
//  deframes 8N1 (8 data, LSB first, 1 stop) at 16x oversampling, and hands each good byte over
//  as rx_data plus a one-clk rx_status strobe. The controller pairs consecutive strobes into
//  16-bit operands, so back-to-back frames must never be merged or dropped.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency in Hz
//  BAUD        9600         line rate in bit/s
//  OVERSAMPLE  16           ticks per bit; must be a power of 2 and >= 8
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-high reset
//  rxd         in   1  async serial line, idle high
//  rx_data     out  8  last correctly received byte
//  rx_status   out  1  one-clk strobe: rx_data has just been updated
//  frame_err   out  1  one-clk strobe: stop bit sampled low
//  parity_err  out  1  one-clk strobe: parity mismatch (tied 0 unless RX_PARITY_EN)
//  rx_busy     out  1  high from start-bit detection until return to IDLE
// BEHAVIOUR
//  - Reset: rx_data=0, rx_status=0, frame_err=0, parity_err=0, rx_busy=0, FSM=IDLE,
//    synchroniser flops=1, tick divider=0, bit/sample counters=0. Reset mid-frame aborts with no strobe.
//  - rxd goes through a 2-flop synchroniser (rxd_s); all decisions use rxd_s only.
//  - Tick divider: DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)) (651 at defaults); emits a 1-clk tick
//    every DIV clks; restarted at 0 on start detection so sampling is aligned to the edge.
//  - Sample counter (log2 OVERSAMPLE bits) counts ticks within a bit; mid-bit = OVERSAMPLE/2-1 (7).
//  - FSM:
//    IDLE: rxd_s 1->0 edge -> START, rx_busy=1, counters cleared.
//    START: at mid-bit, rxd_s=1 -> IDLE (glitch, no strobe); rxd_s=0 -> DATA on bit wrap.
//    DATA: sample rxd_s at mid-bit, shift into shadow reg LSB first; after bit 7 -> STOP
//      (-> PARITY if RX_PARITY_EN).
//    STOP: at mid-bit, rxd_s=1 -> next clk rx_data<=shadow, rx_status=1 for 1 clk, -> IDLE
//      immediately (without waiting out the rest of the stop bit, so a start edge
//      half a bit later is caught); rxd_s=0 -> frame_err=1 for 1 clk, rx_data unchanged, -> WAIT_IDLE.
//    WAIT_IDLE: stays until rxd_s=1 (break / line held low), then -> IDLE; no edge detection here.
//  - Latency: rx_status rises 2 sync clks + ~9.5 bit times (+/- 1 tick) after the start edge on rxd.
//  - rx_data is never written on error; it holds the last good byte indefinitely.
//  - Strobes are mutually exclusive; at most one strobe per frame.
//  - Start edge arriving in the same clk the STOP strobe fires is honoured (IDLE edge detect uses
//    the registered previous rxd_s, which is 1 during the stop bit).
// CONFIGURATION
//  - RX_PARITY_EN defined: frame is 8E1; PARITY state samples the bit after D7 at mid-bit;
//    data XOR parity must be 0. Mismatch -> parity_err 1-clk strobe in place of rx_status, rx_data
//    unchanged; STOP still sampled and, if also low, frame_err takes priority over parity_err.
//  - RX_PARITY_EN undefined: no PARITY state, 8N1 framing, parity_err tied to 0.
// STRUCTURE
//  - Shared package uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE),
//    DATA_BITS=8, default OVERSAMPLE, DIV computation function; reused by the transmitter.
//  - One sub-module: uart_baud_tick (divider with sync restart input, tick output, DIV parameter).
//  - Synchroniser, counters, shifter and FSM stay in this module.
// TESTING (defaults, bit time = 16 ticks = 10416 clks)
//  1. Send 0x55 8N1 -> exactly one rx_status pulse of 1 clk, rx_data=0x55, rx_busy low after.
//  2. rxd low for 3 ticks then high -> no strobe, rx_data unchanged, FSM back in IDLE.
//  3. Good 0x3C, then 0xA3 with stop bit 0 -> frame_err 1 clk, rx_data stays 0x3C; line held low
//     20 bit times -> no strobes until it goes high; next 0x01 received correctly.
//  4. 0x12 then 0x34 back-to-back, single stop bit, sender +2% fast -> two rx_status pulses
//     ~10 bit times apart, rx_data 0x12 then 0x34.
//  5. Assert reset at mid-D4 of 0xFF -> all outputs 0 at once, no strobe; next 0x81 received.
//  6. RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err 1 clk, no rx_status; with parity 1 ->
//     rx_status, rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the baud divider computation.
// The receiver and transmitter both import this package.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } uart_state_e;

  localparam int unsigned DATA_BITS          = 8;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  // Clocks per oversample tick, rounded to nearest: round(clk_hz / (baud * oversample))
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned den;
    den = baud * oversample;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clks. A synchronous restart zeroes the
// count so the tick phase can be realigned to an incoming start edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count 0..DIV-1 and tick on the terminal count; restart wins over the tick
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 2-flop synchroniser, 16x oversampled 8N1 deframer and byte handover
// with one-clk rx_status / frame_err strobes. Define RX_PARITY_EN for 8E1 framing with a
// parity_err strobe; otherwise parity_err is tied low.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int unsigned Div   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned SampW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam logic [SampW-1:0] MidBit     = SampW'(OVERSAMPLE / 2 - 1);
  localparam logic [SampW-1:0] LastSample = SampW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  LastBit    = BitW'(DATA_BITS - 1);

  logic rxd_meta_q, rxd_s_q, rxd_prev_q;
  logic restart, tick, mid, wrap;

  uart_state_e          state_q, state_d;
  logic [SampW-1:0]     samp_q, samp_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_status_q, rx_status_d;
  logic                 frame_err_q, frame_err_d;
`ifdef RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 parity_err_q, parity_err_d;
`endif

  uart_baud_tick #(
    .DIV(Div)
  ) u_baud_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Synchroniser plus one extra stage holding the previous synchronised level for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_prev_q <= rxd_s_q;
    end
  end

  // Deframing FSM: next state, counters, shifter and strobe generation
  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_status_d = 1'b0;
    frame_err_d = 1'b0;
    restart     = 1'b0;
`ifdef RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif
    mid  = tick && (samp_q == MidBit);
    wrap = tick && (samp_q == LastSample);
    // OVERSAMPLE is a power of two, so the sample counter wraps on its own
    if (tick) samp_d = samp_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (rxd_prev_q && !rxd_s_q) begin
          state_d = StStart;
          samp_d  = '0;
          bit_d   = '0;
          restart = 1'b1;
        end
      end
      StStart: begin
        if (mid && rxd_s_q) begin
          state_d = StIdle;  // start bit not held to mid-bit: glitch
        end else if (wrap) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (mid) shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_q == LastBit) begin
`ifdef RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef RX_PARITY_EN
      StParity: begin
        if (mid) par_bit_d = rxd_s_q;
        if (wrap) state_d = StStop;
      end
`endif
      StStop: begin
        // Decide at mid stop bit and return to idle at once so a following start edge is caught
        if (mid) begin
          if (rxd_s_q) begin
            state_d = StIdle;
`ifdef RX_PARITY_EN
            if (^shift_q ^ par_bit_q) begin
              parity_err_d = 1'b1;
            end else begin
              rx_status_d = 1'b1;
              rx_data_d   = shift_q;
            end
`else
            rx_status_d = 1'b1;
            rx_data_d   = shift_q;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (rxd_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, counter, shifter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      samp_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_status_q <= rx_status_d;
      frame_err_q <= frame_err_d;
`ifdef RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_status = rx_status_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != StIdle);
`ifdef RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend at a scaled-down rate (5 clks per tick, 80 clks per bit).
// A frame-level model predicts one event per frame with its time window; one compare process
// checks strobes and rx_data against it every cycle.
module tb_uart_rx_frontend;

  localparam int unsigned CLK_HZ = 2_000_000;
  localparam int unsigned BAUD   = 25_000;
  localparam int unsigned OS     = 16;
  localparam int DIV = 5;                   // 2e6 / (25e3 * 16)
  localparam int BIT = DIV * 16;            // 80 clks per bit
  localparam int LAT = 2 + (19 * BIT) / 2;  // 2 sync clks + 9.5 bit times
  localparam int TOL = DIV + 2;
  localparam int KStatus = 0, KFerr = 1, KPerr = 2;
`ifdef RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    int         kind;
    logic [7:0] data;
    longint     t_exp;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_status, frame_err, parity_err, rx_busy;

  longint     cyc = 0;
  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;
  longint     status_cycs[$];
  longint     ferr_cycs[$];
  longint     perr_cycs[$];
  longint     last_edge = 0;
  int         n_vec = 0;
  int         n_err = 0;

  uart_rx_frontend #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Drive one frame and predict its single outcome from the framing rules
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par, input int bclks);
    ev_t ev;
    @(posedge clk);
    #1;
    rxd       = 1'b0;
    last_edge = cyc;
    ev.data   = d;
    ev.t_exp  = cyc + LAT;
    if (!stop) ev.kind = KFerr;
    else if (PAR_EN && ((^d) ^ par)) ev.kind = KPerr;
    else ev.kind = KStatus;
    exp_q.push_back(ev);
    for (int i = 0; i < 8; i++) begin
      repeat (bclks) @(posedge clk);
      #1;
      rxd = d[i];
    end
    if (PAR_EN) begin
      repeat (bclks) @(posedge clk);
      #1;
      rxd = par;
    end
    repeat (bclks) @(posedge clk);
    #1;
    rxd = stop;
    repeat (bclks) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare process: strobe exclusivity, expected events in their windows, rx_data holding
  always @(negedge clk) begin
    if (!reset) begin
      int  kind;
      ev_t ev;
      chk_rng("strobe_exclusive", int'(rx_status) + int'(frame_err) + int'(parity_err), 0, 1);
      if (rx_status || frame_err || parity_err) begin
        kind = rx_status ? KStatus : (frame_err ? KFerr : KPerr);
        if (rx_status) status_cycs.push_back(cyc);
        if (frame_err) ferr_cycs.push_back(cyc);
        if (parity_err) perr_cycs.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, want none", kind, cyc);
        end else begin
          ev = exp_q.pop_front();
          chk("strobe_kind", kind, ev.kind);
          chk_rng("strobe_time", cyc, ev.t_exp - TOL, ev.t_exp + TOL);
          if (ev.kind == KStatus) model_data = ev.data;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].t_exp + TOL) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_strobe: got none by cycle %0d, want kind %0d near %0d",
                 cyc, exp_q[0].kind, exp_q[0].t_exp);
        void'(exp_q.pop_front());
      end
      chk("rx_data", rx_data, model_data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int ns;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_status", rx_status, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_rx_busy", rx_busy, 0);
    reset = 1'b0;
    idle(20);

    // 1: single good frame
    send_frame(8'h55, 1'b1, 1'b0, BIT);
    idle(2 * BIT);
    chk("t1_status_count", status_cycs.size(), 1);
    chk("t1_rx_data", rx_data, 8'h55);
    chk("t1_rx_busy", rx_busy, 0);
    chk_rng("t1_latency", status_cycs[0] - last_edge, 762, 764);

    // 2: short glitch on the line
    @(posedge clk);
    #1;
    rxd = 1'b0;
    repeat (3 * DIV) @(posedge clk);
    #1;
    rxd = 1'b1;
    idle(5);
    chk("t2_busy_in_start", rx_busy, 1);
    idle(BIT);
    chk("t2_busy_after", rx_busy, 0);
    chk("t2_rx_data", rx_data, 8'h55);
    chk("t2_status_count", status_cycs.size(), 1);

    // 3: good byte, framing error, break, recovery
    send_frame(8'h3C, 1'b1, 1'b0, BIT);
    idle(2 * BIT);
    send_frame(8'hA3, 1'b0, 1'b0, BIT);
    idle(20 * BIT);
    chk("t3_rx_data_held", rx_data, 8'h3C);
    chk("t3_ferr_count", ferr_cycs.size(), 1);
    chk("t3_busy_in_break", rx_busy, 1);
    rxd = 1'b1;
    idle(2 * BIT);
    chk("t3_busy_after_break", rx_busy, 0);
    send_frame(8'h01, 1'b1, 1'b0, BIT);
    idle(2 * BIT);
    chk("t3_rx_data_next", rx_data, 8'h01);

    // 4: back-to-back frames from a fast sender
    ns = status_cycs.size();
    send_frame(8'h12, 1'b1, 1'b0, BIT - 2);
    send_frame(8'h34, 1'b1, 1'b0, BIT - 2);
    idle(2 * BIT);
    chk("t4_status_count", status_cycs.size() - ns, 2);
    chk("t4_rx_data", rx_data, 8'h34);
    if (status_cycs.size() >= ns + 2)
      chk_rng("t4_spacing", status_cycs[ns+1] - status_cycs[ns], 775, 787);

    // 5: reset in the middle of D4 of 0xFF
    @(posedge clk);
    #1;
    rxd = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (4 * BIT + BIT / 2) @(posedge clk);
    #1;
    chk("t5_busy_mid_frame", rx_busy, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_rx_data", rx_data, 0);
    chk("t5_rst_rx_busy", rx_busy, 0);
    chk("t5_rst_rx_status", rx_status, 0);
    chk("t5_rst_frame_err", frame_err, 0);
    model_data = 8'h00;
    exp_q.delete();
    idle(3);
    reset = 1'b0;
    idle(2 * BIT);
    chk("t5_rx_data_zero", rx_data, 0);
    send_frame(8'h81, 1'b1, 1'b0, BIT);
    idle(2 * BIT);
    chk("t5_rx_data_next", rx_data, 8'h81);

`ifdef RX_PARITY_EN
    // 6: even parity
    send_frame(8'h07, 1'b1, 1'b0, BIT);
    idle(2 * BIT);
    chk("t6_perr_count", perr_cycs.size(), 1);
    chk("t6_rx_data_held", rx_data, 8'h81);
    send_frame(8'h07, 1'b1, 1'b1, BIT);
    idle(2 * BIT);
    chk("t6_rx_data", rx_data, 8'h07);
`endif
    chk("perr_total", perr_cycs.size(), PAR_EN ? 1 : 0);

    chk("events_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
